// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 configuration sequencer.
// Contents:
//   state_t              - sequencer FSM states
//   CFG_END, CFG_DELAY   - in-table marker entries
//   DEFAULT_DEVICE_ADDR  - SCCB write address of the OV7670
//   TABLE_*              - selectors for the register table held by the ROM
//   max4                 - helper used to size the shared wait counter
package ov7670_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CAM_RST   = 4'd1,
        ST_PWR_WAIT  = 4'd2,
        ST_FETCH     = 4'd3,
        ST_ISSUE     = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_GAP       = 4'd6,
        ST_DELAY     = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    localparam logic [15:0] CFG_END             = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY           = 16'hFFF0;
    localparam logic [7:0]  DEFAULT_DEVICE_ADDR = 8'h42;

    // Production QVGA RGB565 set, plus two short bring-up tables.
    localparam int TABLE_QVGA       = 0;
    localparam int TABLE_TEST_DELAY = 1; // {12 80, FFF0, 11 01, FFFF}
    localparam int TABLE_TEST_PLAIN = 2; // four plain writes, no end marker

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Synchronous-read register table for the OV7670.
// Each entry is {reg_addr, reg_data}; CFG_DELAY entries request a settle
// wait and CFG_END terminates the table. Unused addresses read CFG_END.
// Ports:
//   clk  - system clock
//   addr - table index (AW bits)
//   data - entry at the address presented on the previous clock edge
module ov7670_reg_rom
    import ov7670_pkg::*;
#(
    parameter int AW        = 7,
    parameter int TABLE_SEL = TABLE_QVGA
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [15:0]   data
);

    // Table lookup; indices are taken as 8 bits (tables hold at most 256 entries).
    function automatic logic [15:0] rom_entry(input int sel, input logic [7:0] i);
        logic [15:0] e;
        e = CFG_END;
        case (sel)
            TABLE_TEST_DELAY: begin
                case (i)
                    8'd0:    e = 16'h1280;
                    8'd1:    e = CFG_DELAY;
                    8'd2:    e = 16'h1101;
                    default: e = CFG_END;
                endcase
            end
            TABLE_TEST_PLAIN: begin
                case (i)
                    8'd0:    e = 16'h1280;
                    8'd1:    e = 16'h1101;
                    8'd2:    e = 16'h1D55;
                    8'd3:    e = 16'h1EAA;
                    default: e = CFG_END;
                endcase
            end
            default: begin
                case (i)
                    8'd0:    e = 16'h1280; // COM7: soft reset
                    8'd1:    e = CFG_DELAY; // let the sensor settle after soft reset
                    8'd2:    e = 16'h1214; // COM7: QVGA, RGB output
                    8'd3:    e = 16'h1180; // CLKRC: use input clock directly
                    8'd4:    e = 16'h0C04; // COM3: DCW enable for scaling
                    8'd5:    e = 16'h3E19; // COM14: scaled PCLK, divide by 2
                    8'd6:    e = 16'h40D0; // COM15: RGB565, full output range
                    8'd7:    e = 16'h3A04; // TSLB
                    8'd8:    e = 16'h1438; // COM9: AGC ceiling
                    8'd9:    e = 16'h4FB3; // colour matrix
                    8'd10:   e = 16'h50B3;
                    8'd11:   e = 16'h5100;
                    8'd12:   e = 16'h523D;
                    8'd13:   e = 16'h53A7;
                    8'd14:   e = 16'h54E4;
                    8'd15:   e = 16'h589E;
                    8'd16:   e = 16'h3DC0; // COM13: gamma, UV auto adjust
                    8'd17:   e = 16'h1716; // HSTART
                    8'd18:   e = 16'h1804; // HSTOP
                    8'd19:   e = 16'h3280; // HREF
                    8'd20:   e = 16'h1902; // VSTART
                    8'd21:   e = 16'h1A7A; // VSTOP
                    8'd22:   e = 16'h030A; // VREF
                    8'd23:   e = 16'h703A; // scaling X
                    8'd24:   e = 16'h7135; // scaling Y
                    8'd25:   e = 16'h7211; // downsample by 2
                    8'd26:   e = 16'h73F1; // DSP clock divide by 2
                    8'd27:   e = 16'hA202; // pixel clock delay
                    8'd28:   e = 16'h0F41; // COM6
                    8'd29:   e = 16'h1E00; // MVFP: no mirror/flip
                    8'd30:   e = 16'h3C78; // COM12
                    8'd31:   e = 16'hB084; // colour fix-up
                    default: e = CFG_END;
                endcase
            end
        endcase
        return e;
    endfunction

    // Registered table read: data is valid one cycle after addr.
    always_ff @(posedge clk) begin
        data <= rom_entry(TABLE_SEL, 8'(addr));
    end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// OV7670 power-up and register configuration sequencer.
// Drives the sensor reset/power-down pins, then walks the register table,
// issuing one SCCB write per entry and honouring in-table delay markers.
// Ports:
//   clk, rst_n       - system clock, asynchronous active-low reset
//   start            - pulse: begin (from IDLE) or re-run (from DONE)
//   sccb_ready       - SCCB master idle
//   sccb_done_tick   - SCCB master finished a write
//   sccb_start       - one-cycle write request
//   sccb_dev_addr    - constant device address
//   sccb_reg_addr/data - register address/data of the current entry
//   cam_rst_n        - sensor hardware reset (active-low)
//   cam_pwdn         - sensor power-down (active-high, held low)
//   busy             - sequence in progress
//   config_done      - table exhausted
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int          CLK_FREQ       = 50_000_000,
    parameter logic [7:0]  DEVICE_ADDR    = DEFAULT_DEVICE_ADDR,
    parameter int          CAM_RST_CYCLES = CLK_FREQ / 1000,
    parameter int          POWERUP_CYCLES = CLK_FREQ / 100,
    parameter int          DELAY_CYCLES   = CLK_FREQ / 100,
    parameter int          GAP_CYCLES     = 256,
    parameter int          ROM_DEPTH      = 128,
    parameter int          TABLE_SEL      = TABLE_QVGA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sccb_ready,
    input  logic       sccb_done_tick,
    output logic       sccb_start,
    output logic [7:0] sccb_dev_addr,
    output logic [7:0] sccb_reg_addr,
    output logic [7:0] sccb_reg_data,
    output logic       cam_rst_n,
    output logic       cam_pwdn,
    output logic       busy,
    output logic       config_done
);

    localparam int AW      = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    // One extra index bit so the index can reach ROM_DEPTH itself.
    localparam int IW      = AW + 1;
    localparam int CNT_MAX = max4(CAM_RST_CYCLES, POWERUP_CYCLES, DELAY_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Down-counter loads: N-1 so the wait ends on the cycle the counter reads 0.
    localparam logic [CNT_W-1:0] CAM_RST_LOAD = CNT_W'(CAM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] POWERUP_LOAD = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD   = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]    IDX_LAST     = IW'(ROM_DEPTH);

    state_t           state_r;
    logic [IW-1:0]    idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic             fetch_phase_r; // 0: address presented, 1: entry valid
    logic [15:0]      rom_data_s;
    logic [AW-1:0]    rom_addr_s;
    logic             cnt_zero_s;

    assign rom_addr_s    = idx_r[AW-1:0];
    assign cnt_zero_s    = (cnt_r == {CNT_W{1'b0}});
    assign sccb_dev_addr = DEVICE_ADDR;
    // Power-down sequencing is not used yet; the sensor is always powered.
    assign cam_pwdn      = 1'b0;

    ov7670_reg_rom #(
        .AW        (AW),
        .TABLE_SEL (TABLE_SEL)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr_s),
        .data (rom_data_s)
    );

    // Sequencer FSM with registered outputs and shared wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IW{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            fetch_phase_r <= 1'b0;
            sccb_start    <= 1'b0;
            sccb_reg_addr <= 8'h00;
            sccb_reg_data <= 8'h00;
            cam_rst_n     <= 1'b1;
            busy          <= 1'b0;
            config_done   <= 1'b0;
        end else begin
            sccb_start <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_CAM_RST;
                        idx_r       <= {IW{1'b0}};
                        cnt_r       <= CAM_RST_LOAD;
                        cam_rst_n   <= 1'b0;
                        busy        <= 1'b1;
                        config_done <= 1'b0;
                    end
                end
                ST_CAM_RST: begin
                    if (cnt_zero_s) begin
                        state_r   <= ST_PWR_WAIT;
                        cnt_r     <= POWERUP_LOAD;
                        cam_rst_n <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_PWR_WAIT: begin
                    if (cnt_zero_s) begin
                        state_r       <= ST_FETCH;
                        fetch_phase_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FETCH: begin
                    if (!fetch_phase_r) begin
                        fetch_phase_r <= 1'b1;
                    end else begin
                        fetch_phase_r <= 1'b0;
                        if ((idx_r == IDX_LAST) || (rom_data_s == CFG_END)) begin
                            state_r     <= ST_DONE;
                            busy        <= 1'b0;
                            config_done <= 1'b1;
                        end else if (rom_data_s == CFG_DELAY) begin
                            state_r <= ST_DELAY;
                            cnt_r   <= DELAY_LOAD;
                        end else begin
                            state_r       <= ST_ISSUE;
                            sccb_reg_addr <= rom_data_s[15:8];
                            sccb_reg_data <= rom_data_s[7:0];
                        end
                    end
                end
                ST_ISSUE: begin
                    // Leaving ISSUE immediately guarantees a single request per entry.
                    if (sccb_ready) begin
                        sccb_start <= 1'b1;
                        state_r    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (sccb_done_tick) begin
                        idx_r   <= idx_r + {{(IW-1){1'b0}}, 1'b1};
                        cnt_r   <= GAP_LOAD;
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero_s) begin
                        state_r       <= ST_FETCH;
                        fetch_phase_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DELAY: begin
                    if (cnt_zero_s) begin
                        idx_r         <= idx_r + {{(IW-1){1'b0}}, 1'b1};
                        state_r       <= ST_FETCH;
                        fetch_phase_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    idx_r         <= {IW{1'b0}};
                    cnt_r         <= {CNT_W{1'b0}};
                    fetch_phase_r <= 1'b0;
                    cam_rst_n     <= 1'b1;
                    busy          <= 1'b0;
                    config_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: two instances (delay-marker table and
// a plain table without end marker) each driven by a behavioural SCCB master.
// Expected writes are queued by the stimulus; monitors pop and compare.
module tb_ov7670_config_sequencer;
    import ov7670_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b, hold_a, inj_done_a;
    logic ready_a_m, ready_b_m, done_a_m, done_b_m;
    logic sccb_ready_a, sccb_ready_b, done_tick_a, done_tick_b;
    logic s_start_a, s_start_b, rst_a, rst_b, pwdn_a, pwdn_b;
    logic busy_a, busy_b, cfg_a, cfg_b;
    logic [7:0] dev_a, dev_b, ra_a, ra_b, rd_a, rd_b;

    assign sccb_ready_a = ready_a_m & ~hold_a;
    assign sccb_ready_b = ready_b_m;
    assign done_tick_a  = done_a_m | inj_done_a;
    assign done_tick_b  = done_b_m;

    ov7670_config_sequencer #(
        .CAM_RST_CYCLES(4), .POWERUP_CYCLES(8), .DELAY_CYCLES(6), .GAP_CYCLES(3),
        .ROM_DEPTH(16), .TABLE_SEL(TABLE_TEST_DELAY)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sccb_ready(sccb_ready_a),
        .sccb_done_tick(done_tick_a), .sccb_start(s_start_a), .sccb_dev_addr(dev_a),
        .sccb_reg_addr(ra_a), .sccb_reg_data(rd_a), .cam_rst_n(rst_a), .cam_pwdn(pwdn_a),
        .busy(busy_a), .config_done(cfg_a)
    );

    ov7670_config_sequencer #(
        .CAM_RST_CYCLES(4), .POWERUP_CYCLES(8), .DELAY_CYCLES(6), .GAP_CYCLES(3),
        .ROM_DEPTH(4), .TABLE_SEL(TABLE_TEST_PLAIN)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sccb_ready(sccb_ready_b),
        .sccb_done_tick(done_tick_b), .sccb_start(s_start_b), .sccb_dev_addr(dev_b),
        .sccb_reg_addr(ra_b), .sccb_reg_data(rd_b), .cam_rst_n(rst_b), .cam_pwdn(pwdn_b),
        .busy(busy_b), .config_done(cfg_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SCCB masters: ready drops on start, done 20 cycles later.
    int mcnt_a, mcnt_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_a_m <= 1'b1; done_a_m <= 1'b0; mcnt_a <= 0;
        end else begin
            done_a_m <= 1'b0;
            if (s_start_a) begin
                ready_a_m <= 1'b0; mcnt_a <= 20;
            end else if (mcnt_a != 0) begin
                mcnt_a <= mcnt_a - 1;
                if (mcnt_a == 1) begin done_a_m <= 1'b1; ready_a_m <= 1'b1; end
            end
        end
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_b_m <= 1'b1; done_b_m <= 1'b0; mcnt_b <= 0;
        end else begin
            done_b_m <= 1'b0;
            if (s_start_b) begin
                ready_b_m <= 1'b0; mcnt_b <= 20;
            end else if (mcnt_b != 0) begin
                mcnt_b <= mcnt_b - 1;
                if (mcnt_b == 1) begin done_b_m <= 1'b1; ready_b_m <= 1'b1; end
            end
        end
    end

    // Ready value each DUT actually sampled at the last rising edge.
    logic rdy_edge_a, rdy_edge_b;
    always @(posedge clk) begin
        rdy_edge_a <= sccb_ready_a;
        rdy_edge_b <= sccb_ready_b;
    end

    logic [23:0] q_a[$];
    logic [23:0] q_b[$];
    int nwr_a = 0, nwr_b = 0, nrst_a = 0, nrst_b = 0, last_done_a = -1;
    logic prev_start_a = 1'b0, prev_start_b = 1'b0;

    // Monitor A: write contents, single-cycle pulse, ready handshake, post-delay spacing.
    always @(negedge clk) begin
        logic [23:0] e;
        if (start_a && (cfg_a || !busy_a)) last_done_a = -1;
        if (!rst_a) nrst_a++;
        if (done_a_m) last_done_a = cyc;
        if (s_start_a) begin
            nwr_a++;
            chk("a_ready_at_start", {31'd0, rdy_edge_a}, 32'd1);
            chk("a_start_width", {31'd0, prev_start_a}, 32'd0);
            if (q_a.size() == 0) fail_now("a_unexpected_write");
            else begin
                e = q_a.pop_front();
                chk("a_write", {8'd0, dev_a, ra_a, rd_a}, {8'd0, e});
            end
            if (last_done_a >= 0) chk("a_gap_ge_9", {31'd0, (cyc - last_done_a) >= 9}, 32'd1);
        end
        prev_start_a = s_start_a;
    end

    // Monitor B: write contents, single-cycle pulse, ready handshake.
    always @(negedge clk) begin
        logic [23:0] e;
        if (!rst_b) nrst_b++;
        if (s_start_b) begin
            nwr_b++;
            chk("b_ready_at_start", {31'd0, rdy_edge_b}, 32'd1);
            chk("b_start_width", {31'd0, prev_start_b}, 32'd0);
            if (q_b.size() == 0) fail_now("b_unexpected_write");
            else begin
                e = q_b.pop_front();
                chk("b_write", {8'd0, dev_b, ra_b, rd_b}, {8'd0, e});
            end
        end
        prev_start_b = s_start_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit which);
        tick();
        if (which) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_cfg(input bit which, input string name);
        int n;
        n = 0;
        while (((which ? cfg_b : cfg_a) !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now({name, "_timeout"});
    endtask

    task automatic push_a2();
        q_a.push_back(24'h421280);
        q_a.push_back(24'h421101);
    endtask

    task automatic push_b4();
        q_b.push_back(24'h421280);
        q_b.push_back(24'h421101);
        q_b.push_back(24'h421D55);
        q_b.push_back(24'h421EAA);
    endtask

    task automatic chk_reset_a(input string name);
        chk({name, "_start"}, {31'd0, s_start_a}, 32'd0);
        chk({name, "_regs"}, {16'd0, ra_a, rd_a}, 32'd0);
        chk({name, "_rst_pwdn_busy_done"}, {28'd0, rst_a, pwdn_a, busy_a, cfg_a}, 32'h8);
    endtask

    initial begin
        int bw, br, n, rel;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; hold_a = 1'b0; inj_done_a = 1'b0;
        repeat (3) tick();
        chk_reset_a("rst_a");
        chk("rst_b", {16'd0, ra_b, rd_b}, 32'd0);
        chk("rst_b_flags", {27'd0, s_start_b, rst_b, pwdn_b, busy_b, cfg_b}, 32'h8);
        // Simultaneous start and reset: reset wins.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk_reset_a("rst_with_start");
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy_done", {30'd0, busy_a, cfg_a}, 32'd0);

        // Run 1: delay table, spurious done tick and start while busy.
        bw = nwr_a; br = nrst_a;
        push_a2();
        pulse(1'b0);
        chk("start_cam_rst_low", {30'd0, rst_a, busy_a}, 32'h1);
        n = 0;
        while (done_a_m !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) fail_now("first_done_timeout");
        tick();
        inj_done_a = 1'b1; start_a = 1'b1;
        tick();
        inj_done_a = 1'b0; start_a = 1'b0;
        wait_cfg(1'b0, "run1");
        chk("run1_writes", nwr_a - bw, 32'd2);
        chk("run1_cam_rst_cycles", nrst_a - br, 32'd4);
        chk("run1_busy_done", {30'd0, busy_a, cfg_a}, 32'h1);
        chk("run1_pwdn", {31'd0, pwdn_a}, 32'd0);
        chk("run1_queue_empty", q_a.size(), 32'd0);

        // Run 2 (re-run from DONE): ready held low across ISSUE.
        bw = nwr_a;
        push_a2();
        pulse(1'b0);
        hold_a = 1'b1;
        repeat (80) tick();
        chk("hold_no_start", nwr_a - bw, 32'd0);
        hold_a = 1'b0;
        rel = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (s_start_a !== 1'b1 && n < 10);
        chk("hold_release_latency", cyc - rel, 32'd1);
        wait_cfg(1'b0, "run2");
        chk("run2_writes", nwr_a - bw, 32'd2);
        chk("run2_queue_empty", q_a.size(), 32'd0);

        // Run 3: reset during WAIT_DONE, then restart from entry 0.
        q_a.push_back(24'h421280);
        pulse(1'b0);
        n = 0;
        while (s_start_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_now("run3_start_timeout");
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_a("midrun_reset");
        chk("midrun_queue_empty", q_a.size(), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bw = nwr_a;
        push_a2();
        pulse(1'b0);
        wait_cfg(1'b0, "run3");
        chk("run3_writes", nwr_a - bw, 32'd2);
        chk("run3_queue_empty", q_a.size(), 32'd0);

        // Instance B: no end marker, index reaching ROM_DEPTH ends the table.
        bw = nwr_b; br = nrst_b;
        push_b4();
        pulse(1'b1);
        wait_cfg(1'b1, "b_run1");
        chk("b_run1_writes", nwr_b - bw, 32'd4);
        chk("b_run1_cam_rst_cycles", nrst_b - br, 32'd4);
        chk("b_run1_busy_done", {30'd0, busy_b, cfg_b}, 32'h1);
        chk("b_run1_queue_empty", q_b.size(), 32'd0);
        bw = nwr_b;
        push_b4();
        pulse(1'b1);
        chk("b_rerun_leaves_done", {31'd0, cfg_b}, 32'd0);
        wait_cfg(1'b1, "b_run2");
        chk("b_run2_writes", nwr_b - bw, 32'd4);
        chk("b_run2_queue_empty", q_b.size(), 32'd0);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
